asyn_fifo_rd_ctrl: RTL and testbench

//  Read-domain controller for the crossbar's asynchronous FIFO; it sits on the read side of the

---
 rtl/asyn_fifo_pkg.sv | 30 +++
 rtl/asyn_fifo_rd_ctrl_sync_2ff.sv | 32 +++
 rtl/asyn_fifo_rd_ctrl.sv | 97 +++++++++
 tb/tb_asyn_fifo_rd_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/asyn_fifo_pkg.sv
// Shared definitions for both sides of the asynchronous FIFO.
//   ptr_t     : pointer type (ADDR_SIZE+1 bits) used by the read- and write-side controllers
//   bin2gray  : binary -> Gray conversion
//   gray2bin  : Gray -> binary conversion
// The conversions work on a zero-extended 32-bit code word, so any pointer width up to 32 bits
// can use them; the caller sizes the result back to its own width.
package asyn_fifo_pkg;

  localparam int FIFO_ADDR_SIZE = 3;
  localparam int CODE_W         = 32;

  typedef logic [FIFO_ADDR_SIZE:0] ptr_t;
  typedef logic [CODE_W-1:0]       code_t;

  function automatic code_t bin2gray(input code_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it; zero upper bits leave the
  // result unaffected, which is what makes this width-independent.
  function automatic code_t gray2bin(input code_t g);
    code_t b;
    b = '0;
    for (int i = 0; i < CODE_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/asyn_fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local clock domain.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both stages
//   d_i   : pointer from the foreign clock domain
//   q_o   : synchronized pointer (second stage)
module sync_2ff
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/asyn_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO.
// Keeps the Gray read pointer, synchronizes the write Gray pointer into rclk, derives empty and
// the memory occupancy, and presents words through a first-word-fall-through output register.
//   rclk        : read clock
//   rrst        : asynchronous active-high reset
//   wgptr_async : write Gray pointer from the write domain (unsynchronized)
//   rgptr       : registered read Gray pointer, to the write domain
//   raddr       : memory read address
//   mem_rdata   : combinational memory data at raddr
//   rvalid      : rdata holds a valid word
//   rready      : consumer takes rdata this cycle
//   rdata       : output data register
//   rempty      : no unread word left in memory (output register not counted)
//   rlevel      : unread words in memory
module asyn_fifo_rd_ctrl
  import asyn_fifo_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic [ADDR_SIZE:0]   wgptr_async,
  output logic [ADDR_SIZE:0]   rgptr,
  output logic [ADDR_SIZE-1:0] raddr,
  input  logic [DATA_SIZE-1:0] mem_rdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rempty,
  output logic [ADDR_SIZE:0]   rlevel
);

  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0]        wq2;
  logic [PW-1:0]        rbin_q,   rbin_d;
  logic [PW-1:0]        rgptr_q,  rgptr_d;
  logic [PW-1:0]        rlevel_q, rlevel_d;
  logic                 rempty_q, rempty_d;
  logic                 rvalid_q, rvalid_d;
  logic [DATA_SIZE-1:0] rdata_q,  rdata_d;
  logic                 fetch;

  sync_2ff #(.WIDTH(PW)) u_sync_wptr (
    .clk_i (rclk),
    .rst_i (rrst),
    .d_i   (wgptr_async),
    .q_o   (wq2)
  );

  // Refill the output register whenever it is empty or being drained this cycle, so a
  // continuous stream pops and refills in the same cycle.
  assign fetch = ~rempty_q & (~rvalid_q | rready);

  always_comb begin
    rbin_d   = rbin_q + PW'(fetch);
    rgptr_d  = PW'(bin2gray(CODE_W'(rbin_d)));
    // Full-width compare: the extra MSB tells a wrapped-full memory apart from an empty one.
    rempty_d = (rgptr_d == wq2);
    rlevel_d = PW'(gray2bin(CODE_W'(wq2))) - rbin_d;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (fetch) begin
      rvalid_d = 1'b1;
      rdata_d  = mem_rdata;
    end else if (rvalid_q && rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rgptr_q  <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgptr_q  <= rgptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rgptr  = rgptr_q;
  assign raddr  = rbin_q[ADDR_SIZE-1:0];
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rempty = rempty_q;
  assign rlevel = rlevel_q;

endmodule

// File: tb/tb_asyn_fifo_rd_ctrl.sv
module tb_asyn_fifo_rd_ctrl;

  logic        rclk;
  logic        rrst;
  logic [3:0]  wgptr_async;
  logic [3:0]  rgptr;
  logic [2:0]  raddr;
  logic [31:0] mem_rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        rempty;
  logic [3:0]  rlevel;

  asyn_fifo_rd_ctrl #(.DATA_SIZE(32), .ADDR_SIZE(3)) dut (
    .rclk        (rclk),
    .rrst        (rrst),
    .wgptr_async (wgptr_async),
    .rgptr       (rgptr),
    .raddr       (raddr),
    .mem_rdata   (mem_rdata),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rempty      (rempty),
    .rlevel      (rlevel)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Write side: word n carries wdata[n % 1024] and lives in memory slot n % 8.
  logic [31:0] wdata [1024];
  logic [31:0] mem   [8];
  int          wcnt;
  assign mem_rdata = mem[raddr];

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  function automatic logic [3:0] g4(input int n);
    logic [3:0] b;
    b = n[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic write_word();
    mem[wcnt % 8] = wdata[wcnt % 1024];
    wcnt++;
    wgptr_async = g4(wcnt);
  endtask

  // Reference model in word counts: m_rcnt = words moved into the output register,
  // vis = write count as the reader sees it two edges later.
  int          m_rcnt, vis, v1, m_level;
  bit          m_valid, m_empty, m_fetch;
  logic [31:0] m_data;

  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_rcnt = 0; vis = 0; v1 = 0; m_level = 0;
      m_valid = 0; m_empty = 1; m_data = '0;
    end else begin
      m_fetch = !m_empty && (!m_valid || rready);
      if (m_fetch) begin
        m_data  = wdata[m_rcnt % 1024];
        m_valid = 1;
        m_rcnt++;
      end else if (m_valid && rready) begin
        m_valid = 0;
      end
      m_empty = ((m_rcnt % 16) == (vis % 16));
      m_level = (vis - m_rcnt) % 16;
      if (m_level < 0) m_level += 16;
      vis = v1;
      v1  = wcnt;
    end
  end

  logic [3:0] prev_g;
  logic       prev_e;

  always @(negedge rclk) begin
    if (rrst) begin
      prev_g = '0;
      prev_e = 1'b1;
    end else if (chk_en) begin
      chk("rvalid", {31'd0, rvalid}, {31'd0, m_valid});
      chk("rempty", {31'd0, rempty}, {31'd0, m_empty});
      chk("rlevel", {28'd0, rlevel}, m_level);
      chk("rgptr",  {28'd0, rgptr},  {28'd0, g4(m_rcnt)});
      chk("raddr",  {29'd0, raddr},  m_rcnt % 8);
      chk("rdata",  rdata, m_data);
      chk("gray_step", {31'd0, ($countones(rgptr ^ prev_g) <= 1)}, 32'd1);
      chk("pop_on_empty", {31'd0, ((rgptr != prev_g) && prev_e)}, 32'd0);
      prev_g = rgptr;
      prev_e = rempty;
    end
  end

  initial begin
    bit got;
    rrst = 1'b1;
    rready = 1'b0;
    wgptr_async = '0;
    wcnt = 0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    for (int i = 0; i < 1024; i++) wdata[i] = $urandom;
    wdata[0] = 32'hA5A5_0001;

    repeat (2) @(negedge rclk);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rempty", {31'd0, rempty}, 32'd1);
    chk("rst_rlevel", {28'd0, rlevel}, 32'd0);
    chk("rst_rgptr",  {28'd0, rgptr},  32'd0);
    chk("rst_rdata",  rdata, 32'd0);
    rrst = 1'b0;
    chk_en = 1;

    // First word after reset: latency and pointer/empty/level values.
    @(negedge rclk);
    write_word();
    repeat (3) @(posedge rclk);
    #1;
    chk("e3_rempty", {31'd0, rempty}, 32'd0);
    chk("e3_rlevel", {28'd0, rlevel}, 32'd1);
    chk("e3_rvalid", {31'd0, rvalid}, 32'd0);
    @(posedge rclk);
    #1;
    chk("e4_rvalid", {31'd0, rvalid}, 32'd1);
    chk("e4_rdata",  rdata, 32'hA5A5_0001);
    chk("e4_raddr",  {29'd0, raddr}, 32'd1);
    chk("e4_rgptr",  {28'd0, rgptr}, 32'b0001);
    chk("e4_rempty", {31'd0, rempty}, 32'd1);
    chk("e4_rlevel", {28'd0, rlevel}, 32'd0);

    // Asynchronous reset mid-cycle while holding a valid word.
    @(posedge rclk);
    #3;
    rrst = 1'b1;
    wcnt = 0;
    wgptr_async = '0;
    #1;
    chk("ar_rvalid", {31'd0, rvalid}, 32'd0);
    chk("ar_rempty", {31'd0, rempty}, 32'd1);
    chk("ar_rgptr",  {28'd0, rgptr},  32'd0);
    chk("ar_rlevel", {28'd0, rlevel}, 32'd0);
    chk("ar_rdata",  rdata, 32'd0);
    @(posedge rclk);
    #3;
    rrst = 1'b0;

    // Full memory (write pointer gray(8)) streamed out with rready held high.
    @(negedge rclk);
    for (int i = 0; i < 8; i++) write_word();
    rready = 1'b1;
    repeat (3) @(posedge rclk);
    #1;
    chk("full_rempty", {31'd0, rempty}, 32'd0);
    chk("full_rlevel", {28'd0, rlevel}, 32'd8);
    for (int k = 0; k < 8; k++) begin
      @(posedge rclk);
      #1;
      chk("str_rvalid", {31'd0, rvalid}, 32'd1);
      chk("str_rdata",  rdata, wdata[k]);
      chk("str_rlevel", {28'd0, rlevel}, 7 - k);
    end
    chk("str_end_rempty", {31'd0, rempty}, 32'd1);
    @(posedge rclk);
    #1;
    chk("str_drained", {31'd0, rvalid}, 32'd0);

    // Backpressure with words waiting, then release; pointer wraps 15 -> 0.
    @(negedge rclk);
    rready = 1'b0;
    for (int i = 0; i < 8; i++) write_word();
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge rclk);
      #1;
      got = rvalid;
    end
    chk("bp_wait_rvalid", {31'd0, got}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge rclk);
      #1;
      chk("bp_rdata", rdata, wdata[8]);
      chk("bp_rgptr", {28'd0, rgptr}, 32'b1101);
    end
    @(negedge rclk);
    rready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(posedge rclk);
      #1;
      chk("bp_pop_rdata", rdata, wdata[8 + k]);
    end
    chk("wrap_rgptr",  {28'd0, rgptr}, 32'd0);
    chk("wrap_rempty", {31'd0, rempty}, 32'd1);

    // Randomized streaming; writer never more than 8 words ahead of the reader.
    for (int c = 0; c < 400; c++) begin
      @(negedge rclk);
      rready = ($urandom_range(0, 3) != 0);
      if (($urandom_range(0, 1) == 1) && (wcnt - m_rcnt < 8)) write_word();
    end

    // Drain everything and confirm the read pointer caught up with the writer.
    @(negedge rclk);
    rready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge rclk);
      #1;
      got = !rvalid && rempty && (rgptr == g4(wcnt));
    end
    chk("drain_rgptr",  {28'd0, rgptr}, {28'd0, g4(wcnt)});
    chk("drain_rvalid", {31'd0, rvalid}, 32'd0);
    chk("drain_rempty", {31'd0, rempty}, 32'd1);
    chk("drain_rlevel", {28'd0, rlevel}, 32'd0);

    @(negedge rclk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
